// File: rtl/gcd_pkg.sv
// Shared GCD definitions: default operand width and the controller command
// encoding with its priority decode (load > sub_a > sub_b).
package gcd_pkg;

  localparam int GCD_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_SUB_A = 2'd2,
    CMD_SUB_B = 2'd3
  } gcd_cmd_e;

  function automatic gcd_cmd_e gcd_decode_cmd(
    input logic ld_a,
    input logic ld_b,
    input logic sub_a,
    input logic sub_b
  );
    gcd_cmd_e cmd;
    if (ld_a | ld_b) begin
      cmd = CMD_LOAD;
    end else if (sub_a) begin
      cmd = CMD_SUB_A;
    end else if (sub_b) begin
      cmd = CMD_SUB_B;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/gcd_compare.sv
// Unsigned magnitude comparator; exactly one of gt/lt/eq is high.
module gcd_compare #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_gt,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_gt = (i_x > i_y);
  assign o_lt = (i_x < i_y);
  assign o_eq = (i_x == i_y);

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: executes controller commands on A/B, reports flags and hands the
// result out on a valid/ready port. Optional GCD_ITER_CNT_EN adds iter_cnt.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             sub_a,
  input  logic             sub_b,
  output logic             a_gt_b,
  output logic             b_gt_a,
  output logic             a_eq_b,
  output logic             busy,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef GCD_ITER_CNT_EN
  output logic [WIDTH-1:0] iter_cnt,
`endif
  output logic             res_ovf
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_valid;
  logic             r_res_ovf;

  logic             w_gt;
  logic             w_lt;
  logic             w_eq;
  gcd_cmd_e         w_cmd;
  logic             w_capture;

  gcd_compare #(.WIDTH(WIDTH)) u_cmp (
    .i_x  (r_a),
    .i_y  (r_b),
    .o_gt (w_gt),
    .o_lt (w_lt),
    .o_eq (w_eq)
  );

  assign w_cmd     = gcd_decode_cmd(ld_a, ld_b, sub_a, sub_b);
  assign w_capture = r_busy & w_eq & (w_cmd == CMD_NONE);

  // Operand registers and busy; subtractions are no-ops unless the minuend is larger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_busy <= 1'b0;
    end else begin
      case (w_cmd)
        CMD_LOAD: begin
          r_busy <= 1'b1;
          if (ld_a && ld_b) begin
            // A zero operand would make the subtract loop spin forever, so collapse to equal.
            if (a_in == {WIDTH{1'b0}}) begin
              r_a <= b_in;
              r_b <= b_in;
            end else if (b_in == {WIDTH{1'b0}}) begin
              r_a <= a_in;
              r_b <= a_in;
            end else begin
              r_a <= a_in;
              r_b <= b_in;
            end
          end else if (ld_a) begin
            r_a <= a_in;
          end else begin
            r_b <= b_in;
          end
        end
        CMD_SUB_A: begin
          if (w_gt) begin
            r_a <= r_a - r_b;
          end
        end
        CMD_SUB_B: begin
          if (w_lt) begin
            r_b <= r_b - r_a;
          end
        end
        CMD_NONE: begin
          if (w_capture) begin
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

  // Result capture and valid/ready handshake; overwriting an unaccepted result is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data  <= {WIDTH{1'b0}};
      r_res_valid <= 1'b0;
      r_res_ovf   <= 1'b0;
    end else if (w_capture) begin
      r_res_data  <= r_a;
      r_res_valid <= 1'b1;
      if (r_res_valid && !res_ready) begin
        r_res_ovf <= 1'b1;
      end
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef GCD_ITER_CNT_EN
  logic [WIDTH-1:0] r_iter_cnt;
  logic             w_sub_exec;

  assign w_sub_exec = ((w_cmd == CMD_SUB_A) & w_gt) | ((w_cmd == CMD_SUB_B) & w_lt);

  // Executed-subtraction counter: cleared by load, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter_cnt <= {WIDTH{1'b0}};
    end else if (w_cmd == CMD_LOAD) begin
      r_iter_cnt <= {WIDTH{1'b0}};
    end else if (w_sub_exec && (r_iter_cnt != {WIDTH{1'b1}})) begin
      r_iter_cnt <= r_iter_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign iter_cnt = r_iter_cnt;
`endif

  assign a_gt_b    = w_gt;
  assign b_gt_a    = w_lt;
  assign a_eq_b    = w_eq;
  assign busy      = r_busy;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign res_ovf   = r_res_ovf;

endmodule
